decoder_sequencer: RTL and testbench
====================================

// Module: decoder_sequencer
// PURPOSE
//  Top-level scheduler for the image decoder. Owns the single external SRAM port.
//  After a Start pulse it grants SRAM to the UART loader, then runs the enabled
//  milestones in decode order M3 -> M2 -> M1. Only the current owner's SRAM
//  address, write data and write enable reach the SRAM.
//  Adds a turnaround cycle between owners, a per-stage watchdog and stage cycle counters.
// PARAMETERS
//  STAGE_MASK      3'b111  bit2=M3, bit1=M2, bit0=M1; 0 = skip that stage
//  TIMEOUT_CYCLES  2**22   max cycles a stage may own SRAM before error
//  CNT_W           23      width of stage cycle counter
// PORTS
//  Clock              in   1   system clock (50 MHz)
//  Resetn             in   1   synchronous, active-low reset
//  Start              in   1   1-cycle pulse, begin a decode run
//  UART_Done          in   1   pulse/level, UART image load complete
//  UART_SRAM_address  in   18  } UART loader SRAM request
//  UART_SRAM_write_data in 16  }
//  UART_SRAM_we_n     in   1   }
//  Mx_SRAM_address    in   18  } one bundle each for x = 1, 2, 3
//  Mx_SRAM_write_data in   16  }
//  Mx_SRAM_we_n       in   1   }
//  Mx_Stop            in   1   } milestone x finished (pulse or level)
//  Mx_Enable          out  1   } held high while milestone x owns SRAM
//  SRAM_address       out  18  to SRAM controller
//  SRAM_write_data    out  16  to SRAM controller
//  SRAM_we_n          out  1   to SRAM controller, active-low
//  UART_Enable        out  1   high while UART owns SRAM
//  Busy               out  1   high in any state except S_IDLE/S_DONE/S_ERR
//  Done               out  1   high in S_DONE
//  Error              out  1   high in S_ERR
//  Stage_Cycles       out  CNT_W  cycle count of last completed stage
// BEHAVIOUR
//  State register:
//   - FSM states: S_IDLE, S_LOAD, S_GAP, S_M3, S_M2, S_M1, S_DONE, S_ERR.
//   - Next_stage register: 2 bits.
//  Reset:
//   - Resetn=0 at a rising edge: state<=S_IDLE; all counters<=0; Stage_Cycles<=0.
//   - Takes effect mid-run as well; whichever unit owned SRAM is dropped immediately.
//  Outputs in S_IDLE/S_GAP/S_DONE/S_ERR (also the reset values):
//   - all Enables=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0.
//  SRAM mux:
//   - Combinational, selected by registered state only (no mux logic from inputs).
//   - Zero added latency: a requester's signal reaches SRAM in the same cycle.
//  S_IDLE:
//   - Start=1 -> S_LOAD.
//  S_LOAD:
//   - UART_Enable=1; UART bundle drives SRAM.
//   - UART_Done=1 -> S_GAP.
//  S_GAP (exactly 1 cycle, SRAM_we_n forced 1):
//   - Goes to the first enabled stage after the previous owner.
//   - If no stage remains -> S_DONE.
//   - STAGE_MASK=0 -> LOAD, GAP, DONE.
//  S_Mx:
//   - Mx_Enable=1; Mx bundle drives SRAM.
//   - Mx_Stop=1 -> Mx_Enable low from the next cycle; Stage_Cycles<=cnt+1; -> S_GAP.
//   - cnt counts cycles in state, starting at 0 on entry.
//  Watchdog:
//   - In S_LOAD or S_Mx, cnt==TIMEOUT_CYCLES-1 with no Done/Stop -> S_ERR.
//   - Done/Stop arriving in that same cycle wins; no error is raised.
//  S_DONE / S_ERR:
//   - Held until Start=1 -> S_LOAD. Error/Done clear on leaving.
//  Inputs ignored:
//   - Stop, Done or Start from a non-owner, or Start while Busy.
//   - A level-held Stop is only acted on in its owner's state.
//  Counter: saturates at all-ones; it never wraps.
// TESTING
//  - Reset then idle: SRAM_we_n=1, addr=0, all Enables=0, Busy=0.
//  - Full run, mask 111:
//    Start; UART_Done@10; M3_Stop@20 cycles; M2_Stop@30; M1_Stop@5
//    -> owners LOAD,M3,M2,M1 in order; 1 gap cycle each with we_n=1;
//       Stage_Cycles=20,30,5 after each stage; Done=1.
//  - Mux isolation: M2 active, M2 addr=18'h1234 we_n=0, M1/M3/UART drive we_n=0 addr=18'h3FFFF
//    -> SRAM sees 18'h1234, we_n=0 only.
//  - Mask 3'b001: Start, UART_Done -> S_GAP -> S_M1 directly; M3_Stop pulses ignored.
//  - Watchdog: TIMEOUT_CYCLES=16, M3 never stops -> Error=1 at cycle 16 of S_M3, we_n=1.
//    Same run with M3_Stop at cycle 15 -> no error.
//  - Resetn=0 mid-M2 while we_n=0 -> next edge: we_n=1, M2_Enable=0, state S_IDLE;
//    Start afterwards restarts from S_LOAD.

Source files
------------

// File: rtl/decoder_sequencer.sv
// decoder_sequencer: owns the external SRAM port and hands it to the UART loader, then to milestones M3 -> M2 -> M1.
// A one-cycle gap separates owners; each owner is watched by a timeout counter.
module decoder_sequencer #(
  parameter logic [2:0] STAGE_MASK = 3'b111,
  parameter int TIMEOUT_CYCLES = 2**22,
  parameter int CNT_W = 23
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic Start,
  input  logic UART_Done,
  input  logic [17:0] UART_SRAM_address,
  input  logic [15:0] UART_SRAM_write_data,
  input  logic UART_SRAM_we_n,
  input  logic [17:0] M1_SRAM_address,
  input  logic [15:0] M1_SRAM_write_data,
  input  logic M1_SRAM_we_n,
  input  logic M1_Stop,
  input  logic [17:0] M2_SRAM_address,
  input  logic [15:0] M2_SRAM_write_data,
  input  logic M2_SRAM_we_n,
  input  logic M2_Stop,
  input  logic [17:0] M3_SRAM_address,
  input  logic [15:0] M3_SRAM_write_data,
  input  logic M3_SRAM_we_n,
  input  logic M3_Stop,
  output logic M1_Enable,
  output logic M2_Enable,
  output logic M3_Enable,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic SRAM_we_n,
  output logic UART_Enable,
  output logic Busy,
  output logic Done,
  output logic Error,
  output logic [CNT_W-1:0] Stage_Cycles
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_M3, S_M2, S_M1, S_DONE, S_ERR} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] next_stage, next_stage_n;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic stop, wd;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign wd = cnt == LIMIT;
  assign stop = (state == S_M3 && M3_Stop) || (state == S_M2 && M2_Stop) || (state == S_M1 && M1_Stop);
  // next_stage records the owner just finished: 0=UART, 1=M3, 2=M2, 3=M1
  always_comb begin
    state_n = state;
    next_stage_n = next_stage;
    case (state)
      S_IDLE, S_DONE, S_ERR: state_n = Start ? S_LOAD : state;
      S_LOAD: begin
        state_n = UART_Done ? S_GAP : wd ? S_ERR : S_LOAD;
        next_stage_n = UART_Done ? 2'd0 : next_stage;
      end
      S_GAP: state_n = (next_stage == 2'd0 && STAGE_MASK[2]) ? S_M3 :
                       (next_stage <= 2'd1 && STAGE_MASK[1]) ? S_M2 :
                       (next_stage <= 2'd2 && STAGE_MASK[0]) ? S_M1 : S_DONE;
      S_M3, S_M2, S_M1: begin
        state_n = stop ? S_GAP : wd ? S_ERR : state;
        next_stage_n = !stop ? next_stage : state == S_M3 ? 2'd1 : state == S_M2 ? 2'd2 : 2'd3;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_IDLE;
      next_stage <= 2'd0;
      cnt <= '0;
      Stage_Cycles <= '0;
    end else begin
      state <= state_n;
      next_stage <= next_stage_n;
      cnt <= state_n != state ? '0 : cnt_inc;
      if (stop) Stage_Cycles <= cnt_inc;
    end
  end
  assign UART_Enable = state == S_LOAD;
  assign M3_Enable = state == S_M3;
  assign M2_Enable = state == S_M2;
  assign M1_Enable = state == S_M1;
  assign Busy = !(state inside {S_IDLE, S_DONE, S_ERR});
  assign Done = state == S_DONE;
  assign Error = state == S_ERR;
  // mux select comes from registered state only; requester data passes straight through
  always_comb begin
    SRAM_address = UART_Enable ? UART_SRAM_address : M3_Enable ? M3_SRAM_address :
                   M2_Enable ? M2_SRAM_address : M1_Enable ? M1_SRAM_address : 18'd0;
    SRAM_write_data = UART_Enable ? UART_SRAM_write_data : M3_Enable ? M3_SRAM_write_data :
                      M2_Enable ? M2_SRAM_write_data : M1_Enable ? M1_SRAM_write_data : 16'd0;
    SRAM_we_n = UART_Enable ? UART_SRAM_we_n : M3_Enable ? M3_SRAM_we_n :
                M2_Enable ? M2_SRAM_we_n : M1_Enable ? M1_SRAM_we_n : 1'b1;
  end
endmodule

// File: tb/tb_decoder_sequencer.sv
// tb_decoder_sequencer: two configurations driven from planned runs; a model expands each plan into a per-cycle expected trace.
module tb_decoder_sequencer;
  typedef enum int {T_IDLE, T_LOAD, T_GAP, T_M3, T_M2, T_M1, T_DONE, T_ERR} tst_t;
  typedef struct {
    tst_t st;
    bit rstn;
    bit start;
    bit udone;
    bit [2:0] stop;
    int sc;
  } rec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int n_fin = 0;
  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, g, $time, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam logic [2:0] MASK = g == 0 ? 3'b111 : 3'b001;
    localparam int TO = g == 0 ? 40 : 16;
    logic rstn, start, uart_done, s1, s2, s3, uw, w1, w2, w3;
    logic [17:0] ua, a1, a2, a3, sram_a;
    logic [15:0] ud, d1, d2, d3, sram_d;
    logic sram_we, en1, en2, en3, uen, busy, done, err;
    logic [7:0] stage_cycles;
    decoder_sequencer #(.STAGE_MASK(MASK), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .Clock(clk), .Resetn(rstn), .Start(start), .UART_Done(uart_done),
      .UART_SRAM_address(ua), .UART_SRAM_write_data(ud), .UART_SRAM_we_n(uw),
      .M1_SRAM_address(a1), .M1_SRAM_write_data(d1), .M1_SRAM_we_n(w1), .M1_Stop(s1),
      .M2_SRAM_address(a2), .M2_SRAM_write_data(d2), .M2_SRAM_we_n(w2), .M2_Stop(s2),
      .M3_SRAM_address(a3), .M3_SRAM_write_data(d3), .M3_SRAM_we_n(w3), .M3_Stop(s3),
      .M1_Enable(en1), .M2_Enable(en2), .M3_Enable(en3),
      .SRAM_address(sram_a), .SRAM_write_data(sram_d), .SRAM_we_n(sram_we),
      .UART_Enable(uen), .Busy(busy), .Done(done), .Error(err), .Stage_Cycles(stage_cycles));
    rec_t tr[$];
    rec_t exp_q[$];
    int sc_m = 0;
    int k = 0;
    int rst_at = -1;
    bit cut = 0;
    tst_t term = T_IDLE;
    task automatic emit(input tst_t st, input bit s, input bit ud_, input bit [2:0] sp);
      rec_t r;
      if (cut) return;
      r.st = st; r.start = s; r.udone = ud_; r.stop = sp; r.sc = sc_m; r.rstn = 1'b1;
      if (k == rst_at) begin
        r.rstn = 1'b0;
        cut = 1'b1;
      end
      tr.push_back(r);
      k++;
    endtask
    // a stop planned beyond TO cycles never arrives in time, so that owner times out
    task automatic run(input int tl, input int t3, input int t2, input int t1, input int ra);
      int ts[3];
      tst_t ms[3];
      bit e;
      ts[0] = t3; ts[1] = t2; ts[2] = t1;
      ms[0] = T_M3; ms[1] = T_M2; ms[2] = T_M1;
      k = 0; cut = 1'b0; rst_at = ra; e = 1'b0;
      emit(term, 1'b1, 1'b0, 3'b000);
      for (int j = 1; j <= tl && j <= TO; j++) emit(T_LOAD, 1'b0, j == tl, 3'b000);
      if (tl > TO) e = 1'b1;
      else emit(T_GAP, 1'b0, 1'b0, 3'b000);
      for (int s = 0; s < 3 && !e; s++) begin
        if (MASK[2-s]) begin
          for (int j = 1; j <= ts[s] && j <= TO; j++) emit(ms[s], 1'b0, 1'b0, j == ts[s] ? 3'b100 >> s : 3'b000);
          if (ts[s] > TO) e = 1'b1;
          else begin
            sc_m = ts[s];
            emit(T_GAP, 1'b0, 1'b0, 3'b000);
          end
        end
      end
      term = e ? T_ERR : T_DONE;
      if (cut) begin
        sc_m = 0;
        term = T_IDLE;
      end
      cut = 1'b0;
      rst_at = -1;
    endtask
    task automatic tail(input int n);
      repeat (n) emit(term, 1'b0, 1'b0, 3'b000);
    endtask
    initial begin
      rec_t r;
      logic [2:0] own;
      rstn = 1'b0; start = 1'b0; uart_done = 1'b0; {s1, s2, s3} = 3'b000;
      {ua, a1, a2, a3} = '0; {ud, d1, d2, d3} = '0; {uw, w1, w2, w3} = 4'hf;
      tail(2);
      if (g == 0) begin
        run(10, 20, 30, 5, -1); tail(3);
        run(4, 3, 10, 5, 12); tail(2);
        run(3, 2, 2, 2, -1); tail(2);
        run(5, 50, 1, 1, -1); tail(3);
        run(5, 40, 1, 1, -1); tail(2);
        run(60, 1, 1, 1, -1); tail(2);
        for (int i = 0; i < 25; i++) begin
          run($urandom_range(1, 45), $urandom_range(1, 45), $urandom_range(1, 45), $urandom_range(1, 45),
              $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 60)) : -1);
          tail($urandom_range(1, 3));
        end
      end else begin
        run(3, 5, 5, 16, -1); tail(2);
        run(3, 1, 1, 17, -1); tail(2);
        run(2, 1, 1, 6, 5); tail(2);
        for (int i = 0; i < 25; i++) begin
          run($urandom_range(1, 18), 1, 1, $urandom_range(1, 18),
              $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 20)) : -1);
          tail($urandom_range(1, 3));
        end
      end
      foreach (tr[i]) begin
        @(posedge clk);
        #1;
        r = tr[i];
        own = r.st == T_M3 ? 3'b100 : r.st == T_M2 ? 3'b010 : r.st == T_M1 ? 3'b001 : 3'b000;
        rstn = r.rstn;
        start = r.start | ((r.st inside {T_LOAD, T_GAP, T_M3, T_M2, T_M1}) && $urandom_range(0, 5) == 0);
        uart_done = r.udone | (r.st != T_LOAD && $urandom_range(0, 5) == 0);
        {s3, s2, s1} = r.stop | (3'($urandom) & 3'($urandom) & ~own);
        ua = 18'($urandom); a1 = 18'($urandom); a2 = 18'($urandom); a3 = 18'($urandom);
        ud = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom); d3 = 16'($urandom);
        {uw, w1, w2, w3} = 4'($urandom);
        exp_q.push_back(r);
      end
      @(posedge clk);
      #1;
      n_fin++;
    end
    rec_t m;
    logic [17:0] ea;
    logic [15:0] ed;
    logic ew;
    always @(negedge clk) begin
      if (exp_q.size() != 0) begin
        m = exp_q.pop_front();
        ea = m.st == T_LOAD ? ua : m.st == T_M3 ? a3 : m.st == T_M2 ? a2 : m.st == T_M1 ? a1 : 18'd0;
        ed = m.st == T_LOAD ? ud : m.st == T_M3 ? d3 : m.st == T_M2 ? d2 : m.st == T_M1 ? d1 : 16'd0;
        ew = m.st == T_LOAD ? uw : m.st == T_M3 ? w3 : m.st == T_M2 ? w2 : m.st == T_M1 ? w1 : 1'b1;
        chk("uart_enable", g, 32'(uen), 32'(m.st == T_LOAD));
        chk("m_enables", g, 32'({en3, en2, en1}), 32'({m.st == T_M3, m.st == T_M2, m.st == T_M1}));
        chk("busy", g, 32'(busy), 32'(m.st inside {T_LOAD, T_GAP, T_M3, T_M2, T_M1}));
        chk("done", g, 32'(done), 32'(m.st == T_DONE));
        chk("error", g, 32'(err), 32'(m.st == T_ERR));
        chk("sram_address", g, 32'(sram_a), 32'(ea));
        chk("sram_write_data", g, 32'(sram_d), 32'(ed));
        chk("sram_we_n", g, 32'(sram_we), 32'(ew));
        chk("stage_cycles", g, 32'(stage_cycles), 32'(m.sc));
      end
    end
  end
  initial begin
    fork
      wait (n_fin == 2);
      #2000000;
    join_any
    if (n_fin != 2) begin
      n_bad++;
      $display("FAIL sim_timeout: got %0d finished drivers expected 2", n_fin);
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
